// File: rtl/fetch_unit.sv
// Instruction-fetch initiator: sequential word fetches with one outstanding request,
// a small {pc, instr} buffer toward decode, and redirect-driven flush/discard.
module fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        instr_enable,
    input  logic        instr_valid,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_result,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    output logic        out_misaligned
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_DROP = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_fetch_pc;
    logic             r_en;
    logic [31:0]      r_addr;
    logic [31:0]      r_mem_pc    [FIFO_DEPTH];
    logic [31:0]      r_mem_instr [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_out_valid;

    logic [1:0]       w_state_nxt;
    logic [31:0]      w_fetch_pc_nxt;
    logic             w_en_nxt;
    logic [31:0]      w_addr_nxt;
    logic             w_push;
    logic             w_pop;
    logic [CNT_W-1:0] w_count_nxt;

    // Next-state and fetch control; the enable drops only after a response is seen
    always_comb begin
        w_state_nxt    = r_state;
        w_fetch_pc_nxt = r_fetch_pc;
        w_en_nxt       = r_en;
        w_addr_nxt     = r_addr;
        w_push         = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end else if ((r_count < CNT_W'(FIFO_DEPTH)) && (r_fetch_pc[1:0] == 2'b00)) begin
                    w_state_nxt = S_REQ;
                    w_en_nxt    = 1'b1;
                    w_addr_nxt  = r_fetch_pc;
                end
            end
            S_REQ: begin
                if (instr_valid) begin
                    w_state_nxt = S_IDLE;
                    w_en_nxt    = 1'b0;
                    if (redirect) begin
                        w_fetch_pc_nxt = redirect_pc;
                    end else begin
                        w_push         = 1'b1;
                        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
                    end
                end else if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                    w_state_nxt    = S_DROP;
                end
            end
            S_DROP: begin
                if (redirect) begin
                    w_fetch_pc_nxt = redirect_pc;
                end
                if (instr_valid) begin
                    w_state_nxt = S_IDLE;
                    w_en_nxt    = 1'b0;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    // Buffer occupancy; a redirect flushes and overrides any same-cycle pop
    always_comb begin
        w_pop       = r_out_valid && out_ready && !redirect;
        w_count_nxt = r_count;
        if (redirect) begin
            w_count_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_fetch_pc  <= RESET_PC;
            r_en        <= 1'b0;
            r_addr      <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_out_valid <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                r_mem_pc[i]    <= '0;
                r_mem_instr[i] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_fetch_pc  <= w_fetch_pc_nxt;
            r_en        <= w_en_nxt;
            r_addr      <= w_addr_nxt;
            r_count     <= w_count_nxt;
            r_out_valid <= (w_count_nxt != '0);
            if (redirect) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_mem_pc[r_wr_ptr]    <= r_fetch_pc;
                    r_mem_instr[r_wr_ptr] <= instr_result;
                    r_wr_ptr              <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    assign instr_enable   = r_en;
    assign instr_addr     = r_addr;
    assign out_valid      = r_out_valid;
    assign out_instr      = r_mem_instr[r_rd_ptr];
    assign out_pc         = r_mem_pc[r_rd_ptr];
    assign out_misaligned = (r_fetch_pc[1:0] != 2'b00);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: memory responder with programmable latency,
// request/pop monitors, and one task per scenario.
module tb_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        instr_enable;
    logic        instr_valid = 1'b0;
    logic [31:0] instr_addr;
    logic [31:0] instr_result = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        out_misaligned;

    int errors = 0;
    int checks = 0;
    int lat = 1;
    int rcnt = 0;
    logic served = 1'b0;
    logic prev_en = 1'b0;
    logic [31:0] prev_addr = 32'h0;
    int addr_viol = 0;
    logic [31:0] req_q[$];
    ent_t pop_q[$];

    fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_enable(instr_enable), .instr_valid(instr_valid),
        .instr_addr(instr_addr), .instr_result(instr_result),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .out_misaligned(out_misaligned)
    );

    always #5 clk = ~clk;

    // Memory responder: one valid pulse per enable window, lat cycles after enable rises
    always @(negedge clk) begin
        instr_valid = 1'b0;
        if (!instr_enable || !rst_n) begin
            served = 1'b0;
            rcnt   = 0;
        end else if (!served) begin
            if (rcnt >= lat - 1) begin
                instr_valid  = 1'b1;
                instr_result = instr_addr ^ 32'hA5A5_0000;
                served       = 1'b1;
            end else begin
                rcnt++;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_enable && !prev_en) req_q.push_back(instr_addr);
            if (instr_enable && prev_en && instr_addr !== prev_addr) addr_viol++;
        end
        prev_en   = instr_enable;
        prev_addr = instr_addr;
    end

    always @(posedge clk) begin
        if (rst_n && out_valid && out_ready && !redirect) pop_q.push_back({out_pc, out_instr});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic apply_reset(input logic rdy);
        rst_n = 1'b0;
        redirect = 1'b0;
        out_ready = rdy;
        step(2);
        req_q.delete();
        pop_q.delete();
        addr_viol = 0;
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        step(2);
        checks++; if (instr_enable !== 1'b0) begin errors++; $display("FAIL reset_en got=%b exp=0", instr_enable); end
        checks++; if (instr_addr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", instr_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++; if ({out_pc, out_instr} !== 64'h0) begin errors++; $display("FAIL reset_out got=%h exp=0", {out_pc, out_instr}); end
        checks++; if (out_misaligned !== 1'b0) begin errors++; $display("FAIL reset_misaligned got=%b exp=0", out_misaligned); end
    endtask

    task automatic test_stream;
        lat = 1;
        apply_reset(1'b1);
        step(14);
        checks++; if (req_q.size() < 3) begin errors++; $display("FAIL stream_req_count got=%0d exp>=3", req_q.size()); end
        checks++; if (req_q[0] !== 32'h0 || req_q[1] !== 32'h4 || req_q[2] !== 32'h8) begin
            errors++; $display("FAIL stream_addrs got=%h,%h,%h exp=0,4,8", req_q[0], req_q[1], req_q[2]); end
        checks++; if (pop_q.size() < 2) begin errors++; $display("FAIL stream_pop_count got=%0d exp>=2", pop_q.size()); end
        checks++; if (pop_q[0] !== {32'h0, 32'hA5A5_0000}) begin errors++; $display("FAIL stream_pop0 got=%h exp=%h", pop_q[0], {32'h0, 32'hA5A5_0000}); end
        checks++; if (pop_q[1] !== {32'h4, 32'hA5A5_0004}) begin errors++; $display("FAIL stream_pop1 got=%h exp=%h", pop_q[1], {32'h4, 32'hA5A5_0004}); end
        checks++; if (addr_viol !== 0) begin errors++; $display("FAIL stream_addr_stable got=%0d exp=0", addr_viol); end
    endtask

    task automatic test_backpressure;
        lat = 1;
        apply_reset(1'b0);
        step(10);
        checks++; if (req_q.size() !== 2) begin errors++; $display("FAIL full_req_count got=%0d exp=2", req_q.size()); end
        checks++; if (req_q[0] !== 32'h0 || req_q[1] !== 32'h4) begin errors++; $display("FAIL full_addrs got=%h,%h exp=0,4", req_q[0], req_q[1]); end
        checks++; if (instr_enable !== 1'b0) begin errors++; $display("FAIL full_en got=%b exp=0", instr_enable); end
        checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) begin errors++; $display("FAIL full_head got=%b/%h exp=1/0", out_valid, out_pc); end
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        step(10);
        checks++; if (req_q.size() !== 3) begin errors++; $display("FAIL refill_req_count got=%0d exp=3", req_q.size()); end
        checks++; if (req_q[2] !== 32'h8) begin errors++; $display("FAIL refill_addr got=%h exp=8", req_q[2]); end
        checks++; if (out_pc !== 32'h4 || out_instr !== 32'hA5A5_0004) begin errors++; $display("FAIL refill_head got=%h/%h exp=4/a5a50004", out_pc, out_instr); end
    endtask

    task automatic test_redirect_req;
        logic found;
        lat = 3;
        apply_reset(1'b1);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (instr_enable && instr_addr == 32'h4) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL redir_req_wait got=timeout exp=request at 4"); end
        redirect = 1'b1;
        redirect_pc = 32'h100;
        step(1);
        redirect = 1'b0;
        checks++; if (instr_enable !== 1'b1 || instr_addr !== 32'h4) begin errors++; $display("FAIL redir_hold got=%b/%h exp=1/4", instr_enable, instr_addr); end
        step(20);
        checks++; if (req_q.size() < 3 || req_q[2] !== 32'h100) begin errors++; $display("FAIL redir_next_addr got=%h exp=100", req_q[2]); end
        checks++; if (pop_q.size() < 2 || pop_q[1] !== {32'h100, 32'hA5A5_0100}) begin
            errors++; $display("FAIL redir_first_pop got=%h exp=%h", pop_q[1], {32'h100, 32'hA5A5_0100}); end
        checks++; if (pop_q[0].pc !== 32'h0) begin errors++; $display("FAIL redir_pop0 got=%h exp=0", pop_q[0].pc); end
        checks++; if (addr_viol !== 0) begin errors++; $display("FAIL redir_addr_stable got=%0d exp=0", addr_viol); end
    endtask

    task automatic test_redirect_valid;
        logic found;
        lat = 2;
        apply_reset(1'b0);
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (instr_enable && instr_addr == 32'h4) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL rv_wait got=timeout exp=request at 4"); end
        step(1);
        redirect = 1'b1;
        redirect_pc = 32'h300;
        out_ready = 1'b1;
        step(1);
        redirect = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rv_flush got=%b exp=0", out_valid); end
        checks++; if (instr_enable !== 1'b0) begin errors++; $display("FAIL rv_en got=%b exp=0", instr_enable); end
        checks++; if (pop_q.size() !== 0) begin errors++; $display("FAIL rv_no_pop got=%0d exp=0", pop_q.size()); end
        step(12);
        checks++; if (req_q.size() < 3 || req_q[2] !== 32'h300) begin errors++; $display("FAIL rv_next_addr got=%h exp=300", req_q[2]); end
        checks++; if (pop_q.size() < 1 || pop_q[0] !== {32'h300, 32'hA5A5_0300}) begin
            errors++; $display("FAIL rv_first_pop got=%h exp=%h", pop_q[0], {32'h300, 32'hA5A5_0300}); end
    endtask

    task automatic test_misalign;
        lat = 1;
        apply_reset(1'b1);
        redirect = 1'b1;
        redirect_pc = 32'h102;
        step(1);
        redirect = 1'b0;
        checks++; if (out_misaligned !== 1'b1) begin errors++; $display("FAIL mis_set got=%b exp=1", out_misaligned); end
        step(8);
        checks++; if (req_q.size() !== 0 || instr_enable !== 1'b0) begin errors++; $display("FAIL mis_no_req got=%0d/%b exp=0/0", req_q.size(), instr_enable); end
        checks++; if (out_misaligned !== 1'b1) begin errors++; $display("FAIL mis_hold got=%b exp=1", out_misaligned); end
        redirect = 1'b1;
        redirect_pc = 32'h200;
        step(1);
        redirect = 1'b0;
        checks++; if (out_misaligned !== 1'b0) begin errors++; $display("FAIL mis_clear got=%b exp=0", out_misaligned); end
        checks++; if (instr_enable !== 1'b0) begin errors++; $display("FAIL mis_no_same_cycle got=%b exp=0", instr_enable); end
        step(6);
        checks++; if (req_q.size() < 1 || req_q[0] !== 32'h200) begin errors++; $display("FAIL mis_next_addr got=%h exp=200", req_q[0]); end
    endtask

    task automatic test_wrap_and_reset;
        logic found;
        lat = 1;
        apply_reset(1'b1);
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step(1);
        redirect = 1'b0;
        step(10);
        checks++; if (req_q.size() < 2 || req_q[0] !== 32'hFFFF_FFFC || req_q[1] !== 32'h0) begin
            errors++; $display("FAIL wrap_addrs got=%h,%h exp=fffffffc,0", req_q[0], req_q[1]); end
        checks++; if (pop_q.size() < 1 || pop_q[0] !== {32'hFFFF_FFFC, 32'h5A5A_FFFC}) begin
            errors++; $display("FAIL wrap_pop got=%h exp=%h", pop_q[0], {32'hFFFF_FFFC, 32'h5A5A_FFFC}); end
        lat = 6;
        found = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step(1);
            if (instr_enable) begin found = 1'b1; break; end
        end
        checks++; if (!found) begin errors++; $display("FAIL midreq_wait got=timeout exp=enable"); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if (instr_enable !== 1'b0 || instr_addr !== 32'h0) begin errors++; $display("FAIL midreq_reset got=%b/%h exp=0/0", instr_enable, instr_addr); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midreq_fifo got=%b exp=0", out_valid); end
        lat = 1;
        step(2);
        req_q.delete();
        rst_n = 1'b1;
        step(6);
        checks++; if (req_q.size() < 1 || req_q[0] !== 32'h0) begin errors++; $display("FAIL midreq_restart got=%h exp=0", req_q[0]); end
    endtask

    initial begin
        test_reset;
        test_stream;
        test_backpressure;
        test_redirect_req;
        test_redirect_valid;
        test_misalign;
        test_wrap_and_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
